sccb_init_seq: RTL

SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

---
 rtl/sccb_init_seq.sv | 390 +++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sccb_init_seq.sv
// ---------------------------------------------------------------------------
// sccb_init_seq
//
// Camera bring-up sequencer. After a `go` pulse it soft-resets the sensor
// (reg 0x12 <= 0x80), waits a settle time, then walks an external
// register-init table and issues each entry as an SCCB write. It finishes by
// reading the two product ID bytes (0x0A, 0x0B) and comparing them against
// the expected values.
//
// Table entry encoding (tbl_data, 16 bits = {sub_addr, data}):
//   16'hFFFF      end of table
//   16'hFExx      settle delay of DELAY_CYCLES (low byte ignored)
//   anything else register write {sub_addr, data}
// Entry 255 is the last entry processed. The address never wraps.
//
// Ports
//   PCLK, PRESET     clock, synchronous active-high reset
//   go               start pulse, honoured only when idle or finished
//   tbl_addr         init-table index (registered ROM, data one cycle later)
//   tbl_data         {sub_addr, data} from the table ROM
//   sccb_start       request strobe, held until sccb_done is sampled high
//   sccb_rw          0 = write, 1 = read
//   sccb_id_addr     device ID byte (WR_ID or RD_ID)
//   sccb_sub_addr    register address
//   sccb_data_in     write data
//   sccb_done        transaction complete from the SCCB master
//   sccb_data_out    read data from the SCCB master
//   busy             sequence in progress
//   seq_done         sequence finished (level, until the next go)
//   pass             ID bytes matched
//   err              0 none, 1 timeout, 2 ID mismatch
//   pid              {byte read from 0x0A, byte read from 0x0B}
//   wr_count         table writes completed (soft reset not counted)
// ---------------------------------------------------------------------------
module sccb_init_seq #(
    parameter logic [7:0]  WR_ID          = 8'h42,
    parameter logic [7:0]  RD_ID          = 8'h43,
    parameter int unsigned DELAY_CYCLES   = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter logic [7:0]  EXP_PID        = 8'h76,
    parameter logic [7:0]  EXP_VER        = 8'h73
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        go,
    output logic [7:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        sccb_start,
    output logic        sccb_rw,
    output logic [7:0]  sccb_id_addr,
    output logic [7:0]  sccb_sub_addr,
    output logic [7:0]  sccb_data_in,
    input  logic        sccb_done,
    input  logic [7:0]  sccb_data_out,
    output logic        busy,
    output logic        seq_done,
    output logic        pass,
    output logic [1:0]  err,
    output logic [15:0] pid,
    output logic [7:0]  wr_count
);

    // Counter widths: each counter only needs to reach (limit - 1).
    localparam int DLY_W = (DELAY_CYCLES > 2) ? $clog2(DELAY_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0]  SRST_SUB  = 8'h12;
    localparam logic [7:0]  SRST_DATA = 8'h80;
    localparam logic [7:0]  PID_SUB   = 8'h0A;
    localparam logic [7:0]  VER_SUB   = 8'h0B;
    localparam logic [15:0] TBL_END   = 16'hFFFF;
    localparam logic [7:0]  TBL_DELAY = 8'hFE;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ID      = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        SRST,
        DELAY,
        FETCH,
        DECODE,
        WRITE,
        RD_PID,
        RD_VER,
        CHECK,
        DONE
    } state_t;

    // Handshake sub-phase shared by all states that talk to the SCCB master.
    //   PH_ARM : wait for sccb_done low, then raise sccb_start
    //   PH_REQ : hold request until sccb_done high (or timeout)
    //   PH_END : wait for sccb_done low again before moving on
    typedef enum logic [1:0] {
        PH_ARM,
        PH_REQ,
        PH_END
    } phase_t;

    state_t             state_q,    state_d;
    phase_t             phase_q,    phase_d;
    logic [DLY_W-1:0]   dly_cnt_q,  dly_cnt_d;
    logic [TO_W-1:0]    to_cnt_q,   to_cnt_d;
    logic               tbl_last_q, tbl_last_d;
    logic [7:0]         wr_sub_q,   wr_sub_d;
    logic [7:0]         wr_data_q,  wr_data_d;
    logic [7:0]         byte_pid_q, byte_pid_d;
    logic [7:0]         byte_ver_q, byte_ver_d;

    logic [7:0]         tbl_addr_q, tbl_addr_d;
    logic               start_q,    start_d;
    logic               rw_q,       rw_d;
    logic [7:0]         id_q,       id_d;
    logic [7:0]         sub_q,      sub_d;
    logic [7:0]         wdata_q,    wdata_d;
    logic               busy_q,     busy_d;
    logic               seq_done_q, seq_done_d;
    logic               pass_q,     pass_d;
    logic [1:0]         err_q,      err_d;
    logic [15:0]        pid_q,      pid_d;
    logic [7:0]         wr_count_q, wr_count_d;

    // Request contents for the current transaction state.
    logic               in_txn;
    logic               txn_done;
    logic [7:0]         req_id;
    logic [7:0]         req_sub;
    logic [7:0]         req_data;
    logic               req_rw;
    logic               id_match;

    assign id_match = (byte_pid_q == EXP_PID) && (byte_ver_q == EXP_VER);

    always_comb begin
        in_txn   = 1'b0;
        req_id   = WR_ID;
        req_sub  = 8'h00;
        req_data = 8'h00;
        req_rw   = 1'b0;
        unique case (state_q)
            SRST: begin
                in_txn   = 1'b1;
                req_sub  = SRST_SUB;
                req_data = SRST_DATA;
            end
            WRITE: begin
                in_txn   = 1'b1;
                req_sub  = wr_sub_q;
                req_data = wr_data_q;
            end
            RD_PID: begin
                in_txn  = 1'b1;
                req_id  = RD_ID;
                req_sub = PID_SUB;
                req_rw  = 1'b1;
            end
            RD_VER: begin
                in_txn  = 1'b1;
                req_id  = RD_ID;
                req_sub = VER_SUB;
                req_rw  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        dly_cnt_d  = dly_cnt_q;
        to_cnt_d   = to_cnt_q;
        tbl_last_d = tbl_last_q;
        wr_sub_d   = wr_sub_q;
        wr_data_d  = wr_data_q;
        byte_pid_d = byte_pid_q;
        byte_ver_d = byte_ver_q;
        tbl_addr_d = tbl_addr_q;
        start_d    = start_q;
        rw_d       = rw_q;
        id_d       = id_q;
        sub_d      = sub_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        seq_done_d = seq_done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        pid_d      = pid_q;
        wr_count_d = wr_count_q;
        txn_done   = 1'b0;

        // Handshake engine. The request fields are latched when start rises
        // so they stay stable for the whole transaction.
        if (in_txn) begin
            unique case (phase_q)
                PH_ARM: begin
                    if (!sccb_done) begin
                        start_d  = 1'b1;
                        id_d     = req_id;
                        sub_d    = req_sub;
                        wdata_d  = req_data;
                        rw_d     = req_rw;
                        to_cnt_d = '0;
                        phase_d  = PH_REQ;
                    end
                end
                PH_REQ: begin
                    if (sccb_done) begin
                        // Read data is only guaranteed in the done cycle.
                        start_d = 1'b0;
                        phase_d = PH_END;
                        if (state_q == RD_PID) begin
                            byte_pid_d = sccb_data_out;
                        end
                        if (state_q == RD_VER) begin
                            byte_ver_d = sccb_data_out;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        // Abandon the whole sequence on a stuck bus.
                        start_d    = 1'b0;
                        err_d      = ERR_TIMEOUT;
                        pass_d     = 1'b0;
                        busy_d     = 1'b0;
                        seq_done_d = 1'b1;
                        phase_d    = PH_ARM;
                        state_d    = DONE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                PH_END: begin
                    if (!sccb_done) begin
                        txn_done = 1'b1;
                        phase_d  = PH_ARM;
                    end
                end
                default: phase_d = PH_ARM;
            endcase
        end

        // Sequence control.
        unique case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    pass_d     = 1'b0;
                    err_d      = ERR_NONE;
                    pid_d      = '0;
                    wr_count_d = '0;
                    tbl_addr_d = '0;
                    tbl_last_d = 1'b0;
                    busy_d     = 1'b1;
                    seq_done_d = 1'b0;
                    phase_d    = PH_ARM;
                    state_d    = SRST;
                end
            end
            SRST: begin
                if (txn_done) begin
                    dly_cnt_d = '0;
                    state_d   = DELAY;
                end
            end
            DELAY: begin
                if (dly_cnt_q == DLY_LAST) begin
                    // A delay entry in the final table slot goes straight
                    // to the ID reads instead of refetching.
                    state_d = tbl_last_q ? RD_PID : FETCH;
                end else begin
                    dly_cnt_d = dly_cnt_q + DLY_W'(1);
                end
            end
            FETCH: begin
                // tbl_addr is already on the ROM; data is valid next cycle.
                state_d = DECODE;
            end
            DECODE: begin
                if (tbl_data == TBL_END) begin
                    state_d = RD_PID;
                end else if (tbl_data[15:8] == TBL_DELAY) begin
                    if (tbl_addr_q == 8'hFF) begin
                        tbl_last_d = 1'b1;
                    end else begin
                        tbl_addr_d = tbl_addr_q + 8'd1;
                    end
                    dly_cnt_d = '0;
                    state_d   = DELAY;
                end else begin
                    wr_sub_d  = tbl_data[15:8];
                    wr_data_d = tbl_data[7:0];
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (txn_done) begin
                    wr_count_d = wr_count_q + 8'd1;
                    if (tbl_addr_q == 8'hFF) begin
                        tbl_last_d = 1'b1;
                        state_d    = RD_PID;
                    end else begin
                        tbl_addr_d = tbl_addr_q + 8'd1;
                        state_d    = FETCH;
                    end
                end
            end
            RD_PID: begin
                if (txn_done) begin
                    state_d = RD_VER;
                end
            end
            RD_VER: begin
                if (txn_done) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                pid_d      = {byte_pid_q, byte_ver_q};
                pass_d     = id_match;
                err_d      = id_match ? ERR_NONE : ERR_ID;
                busy_d     = 1'b0;
                seq_done_d = 1'b1;
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            phase_q    <= PH_ARM;
            dly_cnt_q  <= '0;
            to_cnt_q   <= '0;
            tbl_last_q <= 1'b0;
            wr_sub_q   <= '0;
            wr_data_q  <= '0;
            byte_pid_q <= '0;
            byte_ver_q <= '0;
            tbl_addr_q <= '0;
            start_q    <= 1'b0;
            rw_q       <= 1'b0;
            id_q       <= '0;
            sub_q      <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            pid_q      <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            dly_cnt_q  <= dly_cnt_d;
            to_cnt_q   <= to_cnt_d;
            tbl_last_q <= tbl_last_d;
            wr_sub_q   <= wr_sub_d;
            wr_data_q  <= wr_data_d;
            byte_pid_q <= byte_pid_d;
            byte_ver_q <= byte_ver_d;
            tbl_addr_q <= tbl_addr_d;
            start_q    <= start_d;
            rw_q       <= rw_d;
            id_q       <= id_d;
            sub_q      <= sub_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            seq_done_q <= seq_done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            pid_q      <= pid_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign tbl_addr      = tbl_addr_q;
    assign sccb_start    = start_q;
    assign sccb_rw       = rw_q;
    assign sccb_id_addr  = id_q;
    assign sccb_sub_addr = sub_q;
    assign sccb_data_in  = wdata_q;
    assign busy          = busy_q;
    assign seq_done      = seq_done_q;
    assign pass          = pass_q;
    assign err           = err_q;
    assign pid           = pid_q;
    assign wr_count      = wr_count_q;

endmodule
